// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/control unit.
//   state_t      : control FSM states
//   IDX_*        : pipeline-register index of each stage boundary
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    HALT    = 2'd2
  } state_t;

  localparam int unsigned IDX_IFID  = 0;
  localparam int unsigned IDX_IDEX  = 1;
  localparam int unsigned IDX_EXMEM = 2;
  localparam int unsigned IDX_MEMWB = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst (async, active-low)
//   clr   : synchronous clear, wins over inc
//   inc   : increment request; holds at all ones
//   count : current value
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard and control unit: load-use interlock, redirect flush,
// multi-cycle execute wait with timeout, debug halt and perf counters.
//   clk, rst (async, active-low)
//   id_rs1/id_rs2, id_use_rs1/id_use_rs2 : ID-stage source operands
//   ex_rd, ex_mem_read                   : EX-stage destination / load flag
//   redirect                             : taken branch/jump resolved in EX
//   mc_start, mc_done                    : multi-cycle unit handshake
//   halt_req                             : debug freeze request (level)
//   cnt_clr                              : clear both perf counters
//   en_pc, stall, flush                  : pipeline control (combinational)
//   halted                               : FSM in HALT
//   mc_timeout_err                       : sticky multi-cycle timeout flag
//   stall_cycles, flush_events           : saturating perf counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PREGS  = 4,
  parameter int unsigned REG_SEL    = 5,
  parameter int unsigned EX_IDX     = IDX_IDEX,
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_SEL-1:0]   id_rs1,
  input  logic [REG_SEL-1:0]   id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_SEL-1:0]   ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 redirect,
  input  logic                 mc_start,
  input  logic                 mc_done,
  input  logic                 halt_req,
  input  logic                 cnt_clr,
  output logic                 en_pc,
  output logic [NUM_PREGS-1:0] stall,
  output logic [NUM_PREGS-1:0] flush,
  output logic                 halted,
  output logic                 mc_timeout_err,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_events
);

  localparam int unsigned TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

  // Stage masks: everything up to and including ID/EX, single ID/EX bit,
  // the register after EX, and the fetch register.
  localparam logic [NUM_PREGS-1:0] ONE      = NUM_PREGS'(1);
  localparam logic [NUM_PREGS-1:0] UPTO_EX  = (ONE << (EX_IDX + 1)) - ONE;
  localparam logic [NUM_PREGS-1:0] EX_BIT   = ONE << EX_IDX;
  localparam logic [NUM_PREGS-1:0] POST_EX  = ONE << (EX_IDX + 1);
  localparam logic [NUM_PREGS-1:0] IFID_BIT = ONE << IDX_IFID;

  state_t        state, state_next;
  logic [TW-1:0] tcnt, tcnt_next;
  logic          err_set;
  logic          fe_inc;
  logic          load_use;

  // Load-use hazard: EX load writes a register that ID is about to read.
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // State, timeout counter and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= RUN;
      tcnt           <= '0;
      mc_timeout_err <= 1'b0;
    end else begin
      state <= state_next;
      tcnt  <= tcnt_next;
      if (err_set) begin
        mc_timeout_err <= 1'b1;
      end
    end
  end

  // Next state and zero-latency pipeline controls.
  always_comb begin
    state_next = state;
    tcnt_next  = tcnt;
    err_set    = 1'b0;
    fe_inc     = 1'b0;
    en_pc      = 1'b1;
    stall      = '0;
    flush      = '0;
    halted     = 1'b0;

    case (state)
      RUN: begin
        if (redirect) begin
          flush  = UPTO_EX;
          fe_inc = 1'b1;
        end else if (mc_start) begin
          en_pc      = 1'b0;
          stall      = UPTO_EX;
          flush      = POST_EX;
          state_next = MC_WAIT;
          tcnt_next  = '0;
        end else if (load_use) begin
          en_pc = 1'b0;
          stall = IFID_BIT;
          flush = EX_BIT;
        end else if (halt_req) begin
          state_next = HALT;
        end
      end
      MC_WAIT: begin
        if (mc_done) begin
          state_next = RUN;
          tcnt_next  = '0;
        end else begin
          en_pc = 1'b0;
          stall = UPTO_EX;
          flush = POST_EX;
          if (tcnt == TW'(MC_TIMEOUT - 1)) begin
            err_set    = 1'b1;
            state_next = RUN;
            tcnt_next  = '0;
          end else begin
            tcnt_next = tcnt + TW'(1);
          end
        end
      end
      HALT: begin
        en_pc  = 1'b0;
        stall  = '1;
        halted = 1'b1;
        if (!halt_req) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
        tcnt_next  = '0;
      end
    endcase

    // Reset forces a bubble everywhere and a frozen PC.
    if (!rst) begin
      en_pc  = 1'b0;
      stall  = '0;
      flush  = '1;
      halted = 1'b0;
      fe_inc = 1'b0;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (!en_pc),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (fe_inc),
    .count (flush_events)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int unsigned NP = 4;
  localparam int unsigned RS = 5;
  localparam int unsigned TO = 64;
  localparam int unsigned CW = 4;
  localparam int CMAX = 15;

  localparam int M_RUN  = 0;
  localparam int M_WAIT = 1;
  localparam int M_HALT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [RS-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_mem_read;
  logic          redirect, mc_start, mc_done, halt_req, cnt_clr;
  logic          en_pc, halted, mc_timeout_err;
  logic [NP-1:0] stall, flush;
  logic [CW-1:0] stall_cycles, flush_events;

  pipeline_ctrl #(
    .NUM_PREGS(NP), .REG_SEL(RS), .EX_IDX(1), .MC_TIMEOUT(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .redirect(redirect), .mc_start(mc_start), .mc_done(mc_done),
    .halt_req(halt_req), .cnt_clr(cnt_clr),
    .en_pc(en_pc), .stall(stall), .flush(flush), .halted(halted),
    .mc_timeout_err(mc_timeout_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state (behavioural, from the rules)
  int   m_mode = M_RUN;
  int   m_waited = 0;
  int   m_sc = 0;
  int   m_fe = 0;
  bit   m_err = 1'b0;
  logic e_en, e_h;
  logic [3:0] e_st, e_fl;

  // Observed / expected snapshot:
  // [18] en_pc [17:14] stall [13:10] flush [9] halted [8] err [7:4] stall_cycles [3:0] flush_events
  logic [18:0] obs, expv;

  function automatic bit lu_hazard();
    return ex_mem_read && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  task automatic model_outputs();
    e_en = 1'b1; e_st = 4'b0000; e_fl = 4'b0000; e_h = 1'b0;
    if (!rst) begin
      e_en = 1'b0; e_fl = 4'b1111;
    end else if (m_mode == M_RUN) begin
      if (redirect) e_fl = 4'b0011;
      else if (mc_start) begin e_en = 1'b0; e_st = 4'b0011; e_fl = 4'b0100; end
      else if (lu_hazard()) begin e_en = 1'b0; e_st = 4'b0001; e_fl = 4'b0010; end
    end else if (m_mode == M_WAIT) begin
      if (!mc_done) begin e_en = 1'b0; e_st = 4'b0011; e_fl = 4'b0100; end
    end else begin
      e_en = 1'b0; e_st = 4'b1111; e_h = 1'b1;
    end
  endtask

  task automatic model_step();
    if (cnt_clr) begin
      m_sc = 0; m_fe = 0;
    end else begin
      if (!e_en && m_sc < CMAX) m_sc++;
      if (m_mode == M_RUN && redirect && m_fe < CMAX) m_fe++;
    end
    case (m_mode)
      M_RUN: begin
        if (redirect) ;
        else if (mc_start) begin m_mode = M_WAIT; m_waited = 0; end
        else if (lu_hazard()) ;
        else if (halt_req) m_mode = M_HALT;
      end
      M_WAIT: begin
        if (mc_done) m_mode = M_RUN;
        else begin
          m_waited++;
          if (m_waited == TO) begin m_err = 1'b1; m_mode = M_RUN; end
        end
      end
      default: if (!halt_req) m_mode = M_RUN;
    endcase
  endtask

  // Advance one clock: sample DUT and model at the falling edge, step model at the rising edge.
  task automatic run_cycle();
    @(negedge clk);
    if (!rst) begin m_mode = M_RUN; m_waited = 0; m_sc = 0; m_fe = 0; m_err = 1'b0; end
    model_outputs();
    obs  = {en_pc, stall, flush, halted, mc_timeout_err, stall_cycles, flush_events};
    expv = {e_en, e_st, e_fl, e_h, m_err, 4'(m_sc), 4'(m_fe)};
    @(posedge clk);
    if (rst) model_step();
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd1; id_rs2 = 5'd2; ex_rd = 5'd3;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    redirect = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
    halt_req = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle();
    for (int i = 0; i < 2; i++) begin
      run_cycle();
      tests_run++;
      if (obs !== expv || obs[13:10] !== 4'b1111) begin
        tests_failed++;
        $display("FAIL reset[%0d]: got %h expected %h", i, obs, expv);
      end
    end
    rst = 1'b1;
    run_cycle();
    tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("FAIL reset_release: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_load_use();
    idle(); cnt_clr = 1'b1; run_cycle(); idle();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    run_cycle();
    tests_run++;
    if (obs !== expv || obs[18:10] !== {1'b0, 4'b0001, 4'b0010}) begin
      tests_failed++;
      $display("FAIL load_use: got %h expected %h", obs, expv);
    end
    idle();
    run_cycle();
    tests_run++;
    if (obs !== expv || obs[7:4] !== 4'd1) begin
      tests_failed++;
      $display("FAIL load_use_count: got %h expected %h", obs, expv);
    end
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    run_cycle();
    tests_run++;
    if (obs !== expv || obs[18] !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_use_x0: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_redirect();
    idle(); cnt_clr = 1'b1; run_cycle(); idle();
    redirect = 1'b1; mc_start = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    run_cycle();
    tests_run++;
    if (obs !== expv || obs[18:10] !== {1'b1, 4'b0000, 4'b0011}) begin
      tests_failed++;
      $display("FAIL redirect_prio: got %h expected %h", obs, expv);
    end
    idle();
    run_cycle();
    tests_run++;
    if (obs !== expv || obs[3:0] !== 4'd1) begin
      tests_failed++;
      $display("FAIL redirect_after: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_mc_done();
    idle(); cnt_clr = 1'b1; run_cycle(); idle();
    for (int i = 0; i < 9; i++) begin
      idle();
      if (i == 0) mc_start = 1'b1;
      if (i == 7) mc_done = 1'b1;
      run_cycle();
      tests_run++;
      if (obs !== expv || obs[18] !== (i >= 7)) begin
        tests_failed++;
        $display("FAIL mc_done[%0d]: got %h expected %h", i, obs, expv);
      end
    end
    tests_run++;
    if (obs[7:4] !== 4'd7) begin
      tests_failed++;
      $display("FAIL mc_done_stalls: got %0d expected 7", obs[7:4]);
    end
  endtask

  task automatic test_mc_timeout();
    idle(); mc_start = 1'b1; run_cycle(); idle();
    for (int i = 1; i < 70; i++) begin
      run_cycle();
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL mc_timeout[%0d]: got %h expected %h", i, obs, expv);
      end
    end
    mc_done = 1'b1;
    run_cycle();
    tests_run++;
    if (obs !== expv || obs[8] !== 1'b1 || obs[18] !== 1'b1) begin
      tests_failed++;
      $display("FAIL mc_timeout_sticky: got %h expected %h", obs, expv);
    end
    idle();
  endtask

  task automatic test_halt();
    idle(); cnt_clr = 1'b1; run_cycle(); idle();
    for (int i = 0; i < 6; i++) begin
      idle();
      halt_req = (i < 3);
      redirect = (i == 2);
      run_cycle();
      tests_run++;
      if (obs !== expv || obs[9] !== (i >= 1 && i <= 3)) begin
        tests_failed++;
        $display("FAIL halt[%0d]: got %h expected %h", i, obs, expv);
      end
    end
    tests_run++;
    if (obs[3:0] !== 4'd0) begin
      tests_failed++;
      $display("FAIL halt_redirect_count: got %0d expected 0", obs[3:0]);
    end
  endtask

  task automatic test_saturate_reset();
    idle(); cnt_clr = 1'b1; run_cycle(); idle();
    for (int i = 0; i < 18; i++) begin
      idle(); redirect = 1'b1; run_cycle();
      idle(); ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_use_rs1 = 1'b1;
      run_cycle();
    end
    idle();
    run_cycle();
    tests_run++;
    if (obs !== expv || obs[7:0] !== 8'hFF) begin
      tests_failed++;
      $display("FAIL saturate: got %h expected %h", obs, expv);
    end
    mc_start = 1'b1; run_cycle(); idle();
    run_cycle(); run_cycle();
    rst = 1'b0;
    #1;
    tests_run++;
    if ({en_pc, stall, flush, halted} !== {1'b0, 4'b0000, 4'b1111, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_async: got %b%b%b%b expected 0000011110", en_pc, stall, flush, halted);
    end
    run_cycle();
    tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("FAIL reset_mid_wait: got %h expected %h", obs, expv);
    end
    rst = 1'b1;
    run_cycle();
    run_cycle();
    tests_run++;
    if (obs !== expv || obs[7:0] !== 8'h00 || obs[18] !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_run: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_random();
    idle();
    for (int i = 0; i < 1500; i++) begin
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 9) == 0);
      mc_start    = ($urandom_range(0, 11) == 0);
      mc_done     = ($urandom_range(0, 5) == 0);
      cnt_clr     = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 29) == 0) halt_req = ~halt_req;
      run_cycle();
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL random[%0d]: got %h expected %h", i, obs, expv);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    test_reset();
    test_load_use();
    test_redirect();
    test_mc_done();
    test_mc_timeout();
    test_halt();
    test_saturate_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Parametrised pipeline hazard and control unit for the RV32I in-order core. Drives the per-register stall and flush vectors and the PC enable.
- Handles three conditions: load-use interlock, taken-branch/jump redirect flush, and multi-cycle execute units (MUL/DIV) via a start/done handshake with timeout.
- Sits beside the forwarding and branch units. Generalises the fixed 4-register stall/flush wiring to any pipeline depth and adds debug halt and performance counters.

Parameters:
- NUM_PREGS, 4, number of pipeline registers (IF/ID = index 0 ... MEM/WB = NUM_PREGS-1); minimum 3.
- REG_SEL, 5, register-select width.
- EX_IDX, 1, index of the pipeline register feeding EX (ID/EX).
- MC_TIMEOUT, 64, maximum cycles in MC_WAIT before forced release.
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- id_rs1, id_rs2  in  REG_SEL  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  the ID instruction actually reads rs1 / rs2
- ex_rd  in  REG_SEL  destination register of the instruction in EX
- ex_mem_read  in  1  the instruction in EX is a load
- redirect  in  1  branch unit: taken branch/jump resolved in EX
- mc_start  in  1  the instruction in EX is a multi-cycle op, first cycle
- mc_done  in  1  multi-cycle unit result valid (single-cycle pulse)
- halt_req  in  1  debug freeze request (level)
- cnt_clr  in  1  synchronous clear of both counters
- en_pc  out  1  PC register update enable
- stall  out  NUM_PREGS  hold pipeline register i
- flush  out  NUM_PREGS  load a bubble into pipeline register i
- halted  out  1  FSM is in HALT
- mc_timeout_err  out  1  sticky; set on MC_WAIT timeout
- stall_cycles  out  CNT_WIDTH  cycles with en_pc=0, saturating
- flush_events  out  CNT_WIDTH  accepted redirects, saturating

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to RUN; timeout counter, both performance counters and mc_timeout_err go to 0.
  - While rst=0: en_pc=0, stall=0, flush=all ones, halted=0.
- Outputs are combinational from FSM state and inputs, so there is zero-cycle latency to the pipeline. Counters update on the next clock edge.
- FSM states: RUN, MC_WAIT, HALT.
- RUN, evaluated in priority order:
  1. redirect: flush[0..EX_IDX]=1, en_pc=1, stall=0. flush_events increments. mc_start and load-use are ignored this cycle.
  2. mc_start: transition to MC_WAIT; the timeout counter loads 0. The current cycle already stalls (same outputs as MC_WAIT).
  3. Load-use, defined as ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)): en_pc=0, stall[0]=1, flush[EX_IDX]=1.
  4. halt_req: transition to HALT at the next edge. The current cycle stays normal.
  5. Otherwise: en_pc=1, stall=0, flush=0.
- MC_WAIT:
  - Outputs: en_pc=0, stall[0..EX_IDX]=1, flush[EX_IDX+1]=1 (bubble into EX/MEM), all other bits 0.
  - The timeout counter increments each cycle.
  - On mc_done, go to RUN. The done cycle itself releases: en_pc=1, stall=0, flush=0.
  - If the counter reaches MC_TIMEOUT-1 without mc_done, set mc_timeout_err and go to RUN. The counter is reset on exit.
  - redirect and halt_req are ignored in MC_WAIT. halt_req is honoured on return to RUN if still high.
- HALT: en_pc=0, stall=all ones, flush=0, halted=1. Return to RUN when halt_req=0; the first RUN cycle evaluates normally.
- mc_done received in RUN or HALT is ignored.
- Counters:
  - stall_cycles increments on every cycle with rst=1 and en_pc=0; flush_events increments per redirect accepted in RUN.
  - Both saturate at all ones. cnt_clr takes priority over increment.
- mc_timeout_err clears only on reset.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - the FSM state enum (RUN, MC_WAIT, HALT);
  - pipeline-register index constants IDX_IFID=0, IDX_IDEX=1, IDX_EXMEM=2, IDX_MEMWB=3.
- One sub-module, sat_counter (parameter WIDTH; ports clk, rst, clr, inc, count), instantiated twice for the performance counters.
- Load-use comparison stays inline.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> same cycle en_pc=0, stall=4'b0001, flush=4'b0010; stall_cycles increments by 1. Repeat with ex_rd=0 -> no stall.
- Redirect in the same cycle as load-use and mc_start -> flush=4'b0011, en_pc=1, state stays RUN, flush_events=1.
- mc_start, then mc_done after 7 cycles -> 7 cycles of en_pc=0, stall=4'b0011, flush=4'b0100; the done cycle releases; stall_cycles=7.
- mc_start with no mc_done, MC_TIMEOUT=64 -> mc_timeout_err rises at cycle 64 and stays high; FSM in RUN; a following mc_done is ignored.
- halt_req high for 3 cycles, then low -> halted=1 for 3 cycles with stall=4'b1111 and flush=0; a redirect during HALT is not counted.
- Assert rst=0 mid-MC_WAIT, with counters near saturation (CNT_WIDTH=4, value 15, verify no wrap) -> outputs immediately at reset values with flush=4'b1111; after release, state RUN and counters 0.
